// File: rtl/mux41_rr_arbiter.sv
// rtl/mux41_rr_arbiter.sv - round-robin arbiter with hold quantum driving a shared 4:1 mux select
// Optional ARB_LOCK_EN adds a lock input that suppresses quantum-expiry preemption.
module mux41_rr_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
`ifdef ARB_LOCK_EN
  input  logic       lock,
`endif
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       busy,
  output logic       preempt
);

  typedef enum logic {IDLE, OWN} state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       sel_q, sel_d;
  logic             preempt_q, preempt_d;
  logic             preempt_ok;
  logic [3:0]       others;
  logic [1:0]       win;

`ifdef ARB_LOCK_EN
  assign preempt_ok = ~lock;
`else
  assign preempt_ok = 1'b1;
`endif

  // Lowest rotated offset from p wins; scanning downward lets it overwrite last.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    rr_pick = p;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  assign others = req & ~gnt_q;
  assign win    = rr_pick(req & ~gnt_q, ptr_q);

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    gnt_d      = gnt_q;
    sel_d      = sel_q;
    preempt_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req != 4'b0000) begin
          state_d    = OWN;
          gnt_d      = 4'b0001 << win;
          sel_d      = win;
          ptr_d      = win + 2'd1;
          hold_cnt_d = '0;
        end
      end
      OWN: begin
        if (!req[sel_q]) begin
          if (others != 4'b0000) begin
            gnt_d      = 4'b0001 << win;
            sel_d      = win;
            ptr_d      = win + 2'd1;
            hold_cnt_d = '0;
          end else begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
          end
        end else if (hold_cnt_q == HOLD_LAST && others != 4'b0000 && preempt_ok) begin
          gnt_d      = 4'b0001 << win;
          sel_d      = win;
          ptr_d      = win + 2'd1;
          hold_cnt_d = '0;
          preempt_d  = 1'b1;
        end else if (hold_cnt_q != HOLD_LAST) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= 2'd0;
      hold_cnt_q <= '0;
      gnt_q      <= 4'b0000;
      sel_q      <= 2'b00;
      preempt_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      gnt_q      <= gnt_d;
      sel_q      <= sel_d;
      preempt_q  <= preempt_d;
    end
  end

  assign gnt     = gnt_q;
  assign sel     = sel_q;
  assign busy    = (state_q == OWN);
  assign preempt = preempt_q;

endmodule

// File: tb/tb_mux41_rr_arbiter.sv
// tb/tb_mux41_rr_arbiter.sv - directed self-checking bench for mux41_rr_arbiter
// Covers ARB_LOCK_EN behaviour when the macro is defined.
module tb_mux41_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       lock;
  logic [3:0] gnt8, gnt2;
  logic [1:0] sel8, sel2;
  logic       busy8, busy2, pre8, pre2;
  int         total = 0;
  int         bad   = 0;
  int         owner;

  always #5 clk = ~clk;

  mux41_rr_arbiter #(.MAX_HOLD(8), .CNT_W(8)) u8 (
    .clk(clk), .rst(rst), .req(req),
`ifdef ARB_LOCK_EN
    .lock(lock),
`endif
    .gnt(gnt8), .sel(sel8), .busy(busy8), .preempt(pre8)
  );

  mux41_rr_arbiter #(.MAX_HOLD(2), .CNT_W(8)) u2 (
    .clk(clk), .rst(rst), .req(req),
`ifdef ARB_LOCK_EN
    .lock(lock),
`endif
    .gnt(gnt2), .sel(sel2), .busy(busy2), .preempt(pre2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0000;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    lock = 1'b0;
    do_reset();
    chk("rst_gnt", gnt8, 4'b0000);
    chk("rst_sel", sel8, 2'b00);
    chk("rst_busy", busy8, 1'b0);
    chk("rst_pre", pre8, 1'b0);

    req = 4'b0101; step();
    chk("first_gnt", gnt8, 4'b0001);
    chk("first_sel", sel8, 2'b00);
    chk("first_busy", busy8, 1'b1);
    req = 4'b0100; step();
    chk("handoff_gnt", gnt8, 4'b0100);
    chk("handoff_sel", sel8, 2'b10);
    chk("handoff_busy", busy8, 1'b1);
    chk("handoff_pre", pre8, 1'b0);
    req = 4'b0000; step();
    chk("idle_gnt", gnt8, 4'b0000);
    chk("idle_busy", busy8, 1'b0);
    chk("idle_sel_hold", sel8, 2'b10);

    req = 4'b0100; step();
    chk("pre_rst_gnt", gnt8, 4'b0100);
    rst = 1'b1; step();
    chk("midrst_gnt", gnt8, 4'b0000);
    chk("midrst_sel", sel8, 2'b00);
    chk("midrst_busy", busy8, 1'b0);
    rst = 1'b0; req = 4'b0110; step();
    chk("postrst_gnt", gnt8, 4'b0010);
    chk("postrst_sel", sel8, 2'b01);

    do_reset();
    req = 4'b0011;
    for (int c = 0; c < 32; c++) begin
      step();
      chk("alt_gnt", gnt8, ((c / 8) % 2 == 1) ? 4'b0010 : 4'b0001);
      chk("alt_pre", pre8, (c > 0 && c % 8 == 0) ? 1'b1 : 1'b0);
    end

    do_reset();
    req = 4'b1000;
    for (int c = 0; c < 20; c++) begin
      step();
      chk("solo_gnt", gnt8, 4'b1000);
      chk("solo_pre", pre8, 1'b0);
    end
    chk("solo_hold_sat", u8.hold_cnt_q, 8'd7);

    do_reset();
    req = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      step();
      owner = (c / 2) % 4;
      chk("rr4_gnt", gnt2, 4'b0001 << owner);
      chk("rr4_sel", sel2, owner[1:0]);
      chk("rr4_pre", pre2, (c > 0 && c % 2 == 0) ? 1'b1 : 1'b0);
    end

`ifdef ARB_LOCK_EN
    do_reset();
    req = 4'b0011;
    step();
    lock = 1'b1;
    for (int c = 0; c < 12; c++) begin
      step();
      chk("lock_gnt", gnt8, 4'b0001);
      chk("lock_pre", pre8, 1'b0);
    end
    lock = 1'b0; step();
    chk("unlock_gnt", gnt8, 4'b0010);
    chk("unlock_pre", pre8, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux41_rr_arbiter.md
Name: mux41_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4:1 select datapath (mux41_n, DLEN-wide) between four requesters.
- Produces a registered one-hot grant and the matching 2-bit select that drives mux41_n's sel input directly.
- Holds ownership while the owner keeps requesting, up to a time quantum. When the quantum expires and others are waiting, the owner is preempted.
- Sits between requesting masters (e.g. fetch, load/store, debug, DMA) and a shared memory/bus port.

Parameters:
- MAX_HOLD, 8, quantum: max consecutive grant cycles before preemption when others wait; legal range 1..255.
- CNT_W, 8, width of hold counter; must satisfy 2^CNT_W > MAX_HOLD-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- req  input  4  request level per requester; bit i = requester i (mux input din00..din11 for i=0..3).
- gnt  output  4  registered one-hot grant; all-zero when idle.
- sel  output  2  registered binary index of owner; to mux41_n sel.
- busy  output  1  registered; high when any grant is active (gnt != 0).
- preempt  output  1  one-cycle pulse in the first cycle a grant is issued as a result of a quantum expiry.
- lock  input  1  present only with ARB_LOCK_EN; see Optional Feature.

Behaviour:
- One clock, synchronous active-high reset.
- Reset values: gnt=0, sel=2'b00, busy=0, preempt=0, state=IDLE, ptr=0, hold_cnt=0.
- Reset mid-grant drops gnt on the next edge, with no handoff.
- State and pointer:
  - 2-state FSM: IDLE, OWN.
  - ptr (2-bit) holds the highest-priority index.
  - Search order is ptr, ptr+1, ptr+2, ptr+3 (mod 4). First set req bit wins.
- Latency: req sampled at edge N gives gnt/sel valid after edge N. Arbitration is combinational on registered state; all outputs are registered.
- IDLE:
  - req==0: stay IDLE; sel holds its last value.
  - req!=0: go to OWN. Grant winner w, sel=w, ptr<=w+1, hold_cnt<=0, preempt<=0.
- OWN, owner o, evaluated each edge:
  - req[o]==0 (release), others requesting: zero-bubble handoff to the round-robin winner. ptr<=w+1, hold_cnt<=0, preempt<=0.
  - req[o]==0, no others: go to IDLE, gnt<=0, busy<=0, sel holds.
  - req[o]==1, hold_cnt==MAX_HOLD-1, and (req & ~gnt)!=0: preempt. Grant the winner among the other requesters (o is naturally last since ptr=o+1). hold_cnt<=0, preempt<=1 for one cycle.
  - req[o]==1, otherwise: keep o. hold_cnt<=hold_cnt+1, saturating at MAX_HOLD-1 (no wrap). preempt<=0.
- MAX_HOLD=1: with others waiting, ownership rotates every cycle.
- Invariants:
  - gnt is always one-hot or zero.
  - sel == index of the set gnt bit whenever busy=1.
  - A new requester waits at most 3*MAX_HOLD cycles after its req rises while others hold the resource (fairness bound).

Optional Feature:
- Macro ARB_LOCK_EN.
- Defined:
  - Adds the lock input.
  - While busy and lock=1, the quantum-expiry preemption is suppressed; hold_cnt still saturates.
  - Release by the owner dropping req is unaffected.
  - lock is ignored in IDLE and at the arbitration edge.
- Undefined: no lock port; preemption is always enabled.

Test Plan:
- Reset, then req=4'b0101 at edge 1 -> after edge 1: gnt=0001, sel=00, busy=1. Drop req[0] -> next edge gnt=0100, sel=10, no idle cycle.
- MAX_HOLD=8, req=4'b0011 held constant -> gnt=0001 for 8 cycles, then 0010 for 8 cycles, alternating. preempt=1 on the first cycle of each switch.
- req=4'b1000 only, held 20 cycles -> gnt=1000 stays for all 20 cycles; preempt never asserts; hold_cnt saturates at 7.
- All four requesting continuously, MAX_HOLD=2 -> grant order 0,1,2,3,0, each held 2 cycles. Waiting time never exceeds 6 cycles.
- rst asserted while gnt=0100 -> next edge: gnt=0, sel=00, busy=0. After rst drops with req=4'b0110 -> gnt=0010 (ptr reset to 0).
- ARB_LOCK_EN, req=4'b0011, lock=1 while owner 0 -> gnt=0001 beyond 8 cycles. Deassert lock -> gnt=0010 on the next edge, preempt=1.
